// File: rtl/i2s_pkg.sv
// Shared constants and state encoding for the I2S capture path.
package i2s_pkg;
  localparam int unsigned DEF_DATA_W      = 24;
  localparam int unsigned DEF_SLOT_W      = 32;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned CNT_W           = $clog2(DEF_SLOT_W + 1);

  typedef enum logic [1:0] {
    UNLOCKED,
    LEFT,
    RIGHT
  } rx_state_t;
endpackage

// File: rtl/i2s_sync_edge.sv
// N-stage synchronizer with a history flop; gives the synchronized level and a
// one-Clk rise pulse.
module i2s_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic i_d,
  output logic o_level,
  output logic o_rise
);
  logic [STAGES-1:0] r_sync;
  logic              r_hist;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync[0] <= i_d;
      for (int unsigned i = 1; i < STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_hist <= r_sync[STAGES-1];
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  = r_sync[STAGES-1] & ~r_hist;
endmodule

// File: rtl/i2s_rx.sv
// I2S (Philips, one-bit delay) receiver: oversamples codec SCLK/LRCLK in the Clk
// domain and presents one left/right pair per LRCLK period on valid/ready.
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned SLOT_W      = DEF_SLOT_W,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              sclk,
  input  logic              lrclk,
  input  logic              sdin,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic [DATA_W-1:0] left_data,
  output logic [DATA_W-1:0] right_data,
  output logic              overrun,
  output logic              short_err,
  input  logic              err_clr
);
  // Counter must hold SLOT_W even when SLOT_W is overridden above the default.
  localparam int unsigned BC_W = ($clog2(SLOT_W + 1) > CNT_W) ? $clog2(SLOT_W + 1) : CNT_W;

  logic            w_sclk_rise, w_lr_s, w_sd_s;
  logic [2:0]      w_unused_sync;

  i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .Clk(Clk), .Reset_n(Reset_n), .i_d(sclk), .o_level(w_unused_sync[0]), .o_rise(w_sclk_rise)
  );
  i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_lrclk (
    .Clk(Clk), .Reset_n(Reset_n), .i_d(lrclk), .o_level(w_lr_s), .o_rise(w_unused_sync[1])
  );
  i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sdin (
    .Clk(Clk), .Reset_n(Reset_n), .i_d(sdin), .o_level(w_sd_s), .o_rise(w_unused_sync[2])
  );

  rx_state_t         r_state;
  logic              r_lr_prev;
  logic [BC_W-1:0]   r_bit_cnt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_left_hold;
  logic              r_left_ok;
  logic              r_frame_done;
  logic              r_short_err;
  logic              r_valid;
  logic              r_overrun;
  logic [DATA_W-1:0] r_left_data, r_right_data;

  logic              w_lr_chg, w_adv, w_word_done, w_short_evt, w_ovr_evt;
  logic [BC_W-1:0]   w_cnt_inc;
  logic [DATA_W-1:0] w_shift_next;

  assign w_lr_chg     = w_sclk_rise && (w_lr_s != r_lr_prev);
  assign w_cnt_inc    = r_bit_cnt + 1'b1;
  assign w_adv        = w_sclk_rise && !w_lr_chg && (r_bit_cnt < BC_W'(SLOT_W));
  assign w_word_done  = w_adv && (w_cnt_inc == BC_W'(DATA_W));
  assign w_shift_next = {r_shift[DATA_W-2:0], w_sd_s};
  assign w_short_evt  = w_lr_chg &&
                        (((r_state == LEFT) && !r_left_ok) ||
                         ((r_state == RIGHT) && (r_bit_cnt < BC_W'(DATA_W))));

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state      <= UNLOCKED;
      r_lr_prev    <= 1'b0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_left_hold  <= '0;
      r_left_ok    <= 1'b0;
      r_frame_done <= 1'b0;
      r_short_err  <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_sclk_rise) r_lr_prev <= w_lr_s;
      if (w_lr_chg) begin
        r_bit_cnt <= '0;
      end else if (w_adv) begin
        r_bit_cnt <= w_cnt_inc;
        if (w_cnt_inc <= BC_W'(DATA_W)) r_shift <= w_shift_next;
      end
      // Left word is latched from the shift input directly so right bits can
      // reuse the shift register without a one-Clk gap.
      case (r_state)
        UNLOCKED: begin
          r_left_ok <= 1'b0;
          if (w_lr_chg && !w_lr_s) r_state <= LEFT;
        end
        LEFT: begin
          if (w_word_done) begin
            r_left_hold <= w_shift_next;
            r_left_ok   <= 1'b1;
          end
          if (w_lr_chg) r_state <= RIGHT;
        end
        RIGHT: begin
          if (w_word_done && r_left_ok) r_frame_done <= 1'b1;
          if (w_lr_chg) begin
            r_state   <= LEFT;
            r_left_ok <= 1'b0;
          end
        end
        default: r_state <= UNLOCKED;
      endcase
      if (w_short_evt)  r_short_err <= 1'b1;
      else if (err_clr) r_short_err <= 1'b0;
    end
  end

  assign w_ovr_evt = r_frame_done && r_valid && !frame_ready;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_valid      <= 1'b0;
      r_overrun    <= 1'b0;
      r_left_data  <= '0;
      r_right_data <= '0;
    end else begin
      if (r_frame_done && (!r_valid || frame_ready)) begin
        r_left_data  <= r_left_hold;
        r_right_data <= r_shift;
        r_valid      <= 1'b1;
      end else if (r_valid && frame_ready) begin
        r_valid <= 1'b0;
      end
      if (w_ovr_evt)    r_overrun <= 1'b1;
      else if (err_clr) r_overrun <= 1'b0;
    end
  end

  assign frame_valid = r_valid;
  assign left_data   = r_left_data;
  assign right_data  = r_right_data;
  assign overrun     = r_overrun;
  assign short_err   = r_short_err;
endmodule

// File: tb/tb_i2s_rx.sv
// Randomized bench for i2s_rx: slot-level reference model feeds a scoreboard
// queue; a monitor pops and compares on every frame handshake.
module tb_i2s_rx;
  localparam int unsigned DW = 24;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          sclk = 1'b0, lrclk = 1'b0, sdin = 1'b0;
  logic          frame_ready = 1'b0, err_clr = 1'b0;
  logic          frame_valid, overrun, short_err;
  logic [DW-1:0] left_data, right_data;

  i2s_rx #(.DATA_W(24), .SLOT_W(32), .SYNC_STAGES(2)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .sclk(sclk), .lrclk(lrclk), .sdin(sdin),
    .frame_valid(frame_valid), .frame_ready(frame_ready),
    .left_data(left_data), .right_data(right_data),
    .overrun(overrun), .short_err(short_err), .err_clr(err_clr)
  );

  always #10 Clk = ~Clk;

  int unsigned   checks = 0, errors = 0;
  logic [47:0]   exp_q[$];

  // Slot-level model: lock on a left-slot boundary, emit when both slots hold DW bits.
  logic          m_lr_prev = 1'b0;
  bit            m_locked  = 1'b0;
  int unsigned   m_left_len = 0;
  logic [DW-1:0] m_left_val = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  // One SCLK period: data set while SCLK low, then 8 Clk high. Hooks act on the
  // Clk cycles after the rising edge carrying the right LSB.
  task automatic sclk_bit(input logic lr, input logic d, input int unsigned hook);
    lrclk = lr;
    sdin  = d;
    sclk  = 1'b0;
    repeat (8) tick();
    sclk = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      case (hook)
        1: if (i == 3) frame_ready = 1'b1; else if (i == 4) frame_ready = 1'b0;
        2: err_clr = (i == 3);
        3: begin
          if (i == 3) check("latency_before", {31'd0, frame_valid}, 32'd0);
          if (i == 4) check("latency_at", {31'd0, frame_valid}, 32'd1);
        end
        default: ;
      endcase
    end
  endtask

  task automatic slot(input logic lr, input logic [DW-1:0] data, input int unsigned n,
                      input int unsigned hook, input bit drop);
    logic d;
    if (lr != m_lr_prev) begin
      if (!lr) begin
        m_locked   = 1'b1;
        m_left_len = n;
        m_left_val = data;
      end else if (m_locked && m_left_len > DW && n > DW && !drop) begin
        exp_q.push_back({m_left_val, data});
      end
    end
    m_lr_prev = lr;
    for (int unsigned k = 0; k < n; k++) begin
      d = (k >= 1 && k <= DW) ? data[DW-k] : 1'($urandom);
      sclk_bit(lr, d, (lr && k == DW) ? hook : 0);
    end
  endtask

  task automatic frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                       input int unsigned hook, input bit drop);
    slot(1'b0, l, 32, 0, 1'b0);
    slot(1'b1, r, 32, hook, drop);
  endtask

  task automatic reset_dut(input logic lr);
    Reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sclk = 1'($urandom); lrclk = 1'($urandom); sdin = 1'($urandom);
      frame_ready = 1'($urandom); err_clr = 1'($urandom);
      tick();
    end
    check("rst_valid", {31'd0, frame_valid}, 32'd0);
    check("rst_left", {8'd0, left_data}, 32'd0);
    check("rst_right", {8'd0, right_data}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_short", {31'd0, short_err}, 32'd0);
    sclk = 1'b0; lrclk = lr; sdin = 1'b0; err_clr = 1'b0; frame_ready = 1'b1;
    m_lr_prev = 1'b0; m_locked = 1'b0; m_left_len = 0;
    Reset_n = 1'b1;
    tick();
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tick();
  endtask

  always @(negedge Clk) begin
    if (Reset_n && frame_valid && frame_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame actual=%0h/%0h required=none", left_data, right_data);
      end else begin
        logic [47:0] e;
        e = exp_q.pop_front();
        check("frame_left", {8'd0, left_data}, {8'd0, e[47:24]});
        check("frame_right", {8'd0, right_data}, {8'd0, e[23:0]});
      end
    end
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_dut(1'b0);
    frame_ready = 1'b0;
    slot(1'b0, 24'($urandom), 40, 0, 1'b0);
    check("idle_no_valid", {31'd0, frame_valid}, 32'd0);

    frame_ready = 1'b1;
    slot(1'b1, 24'($urandom), 32, 0, 1'b0);
    frame(24'hABCDEF, 24'h123456, 3, 1'b0);
    for (int i = 0; i < 3; i++) frame(24'($urandom), 24'($urandom), 0, 1'b0);
    check("short_clean", {31'd0, short_err}, 32'd0);

    frame_ready = 1'b0;
    frame(24'h000001, 24'h7FFFFF, 0, 1'b0);
    frame(24'h800000, 24'hFFFFFF, 0, 1'b1);
    check("bp_overrun", {31'd0, overrun}, 32'd1);
    check("bp_valid", {31'd0, frame_valid}, 32'd1);
    check("bp_left_held", {8'd0, left_data}, 32'h000001);
    check("bp_right_held", {8'd0, right_data}, 32'h7FFFFF);
    pulse_err_clr();
    check("bp_overrun_clr", {31'd0, overrun}, 32'd0);
    frame_ready = 1'b1;
    frame(24'($urandom), 24'($urandom), 0, 1'b0);

    frame_ready = 1'b0;
    frame(24'($urandom), 24'($urandom), 0, 1'b0);
    frame(24'h5A5A5A, 24'hC3C3C3, 1, 1'b0);
    check("sim_valid", {31'd0, frame_valid}, 32'd1);
    check("sim_no_overrun", {31'd0, overrun}, 32'd0);
    check("sim_left", {8'd0, left_data}, 32'h5A5A5A);
    check("sim_right", {8'd0, right_data}, 32'hC3C3C3);
    frame(24'($urandom), 24'($urandom), 2, 1'b1);
    check("clr_vs_set", {31'd0, overrun}, 32'd1);
    pulse_err_clr();
    frame_ready = 1'b1;
    repeat (4) tick();

    slot(1'b0, 24'($urandom), 16, 0, 1'b0);
    slot(1'b1, 24'($urandom), 32, 0, 1'b0);
    check("short_set", {31'd0, short_err}, 32'd1);
    frame(24'($urandom), 24'($urandom), 0, 1'b0);
    pulse_err_clr();
    check("short_clr", {31'd0, short_err}, 32'd0);

    reset_dut(1'b1);
    slot(1'b1, 24'($urandom), 14, 0, 1'b0);
    for (int i = 0; i < 2; i++) frame(24'($urandom), 24'($urandom), 0, 1'b0);

    slot(1'b0, 24'($urandom), 12, 0, 1'b0);
    reset_dut(1'b0);
    slot(1'b0, 24'($urandom), 20, 0, 1'b0);
    slot(1'b1, 24'($urandom), 32, 0, 1'b0);
    frame(24'($urandom), 24'($urandom), 0, 1'b0);
    check("post_rst_short", {31'd0, short_err}, 32'd0);

    repeat (40) tick();
    check("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
